// File: rtl/bit_deser_pkg.sv
// Definitions shared by the serializer pair (oserdes / bit_deser): FSM encoding
// and byte/word geometry.
package bit_deser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RX   = 2'd1,
        END  = 2'd2
    } ser_state_t;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int ADDR_STEP  = 4;

endpackage

// File: rtl/bit_deser_byte_packer.sv
// Packs recovered bytes into 32-bit little-lane words and issues RAM writes,
// including the zero-padded flush of a partial word at end of frame.
module bit_deser_byte_packer
    import bit_deser_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_stb,
    input  logic [7:0]        byte_in,
    input  logic              flush,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o
);

    logic [1:0]        lane;
    logic [31:0]       word;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       word_nx;
    logic [2:0]        lane_nx;
    logic              wr;

    // The byte arriving this cycle is merged before the flush decision, so a
    // final byte that coincides with the frame end is part of the flushed word.
    always_comb begin
        word_nx = word;
        lane_nx = {1'b0, lane};
        if (byte_stb) begin
            word_nx[lane*BYTE_W +: BYTE_W] = byte_in;
            lane_nx = lane_nx + 3'd1;
        end
        wr = (lane_nx == 3'(WORD_BYTES)) || (flush && (lane_nx != 3'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= '0;
            word       <= '0;
            waddr      <= '0;
            ram_wr_o   <= 1'b0;
            ram_addr_o <= '0;
            ram_data_o <= '0;
        end else begin
            ram_wr_o <= wr;
            if (start) begin
                lane  <= '0;
                word  <= '0;
                waddr <= '0;
            end else if (wr) begin
                ram_data_o <= word_nx;
                ram_addr_o <= waddr;
                waddr      <= waddr + ADDR_W'(ADDR_STEP);
                word       <= '0;
                lane       <= '0;
            end else begin
                word <= word_nx;
                lane <= lane_nx[1:0];
            end
        end
    end

endmodule

// File: rtl/bit_deser.sv
// Serial-to-byte receiver: recovers MSB-first bytes from a valid-framed bit
// stream, writes packed words to RAM and reports per-frame status.
module bit_deser
    import bit_deser_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    input  logic              bit_valid_in,
    input  logic [LEN_W-1:0]  length_in,
    output logic [7:0]        byte_o,
    output logic              byte_valid_o,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    output logic              done_o,
    output logic [LEN_W-1:0]  byte_cnt_o,
    output logic              err_short_o,
    output logic              err_long_o,
    output logic              err_align_o,
    output logic [1:0]        fsm_state_o
);

    ser_state_t       state;
    logic [7:0]       sr;
    logic [2:0]       bit_cnt;
    logic             byte_rdy;
    logic [LEN_W-1:0] len;

    logic             in_limit;
    logic             emit;
    logic             start;
    logic             flush;
    logic [LEN_W-1:0] cnt_nx;

    // A completed byte waits one cycle in the shift register before it is
    // emitted; that cycle may be the frame-end cycle.
    always_comb begin
        in_limit = (len == '0) || (byte_cnt_o < len);
        emit     = byte_rdy && (state == RX) && in_limit;
        start    = (state == IDLE) && bit_valid_in;
        flush    = (state == RX) && !bit_valid_in;
        cnt_nx   = byte_cnt_o;
        if (emit && (byte_cnt_o != '1))
            cnt_nx = byte_cnt_o + LEN_W'(1);
    end

    assign fsm_state_o = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sr           <= '0;
            bit_cnt      <= '0;
            byte_rdy     <= 1'b0;
            len          <= '0;
            byte_o       <= '0;
            byte_valid_o <= 1'b0;
            done_o       <= 1'b0;
            byte_cnt_o   <= '0;
            err_short_o  <= 1'b0;
            err_long_o   <= 1'b0;
            err_align_o  <= 1'b0;
        end else begin
            byte_valid_o <= emit;
            done_o       <= 1'b0;
            byte_rdy     <= 1'b0;
            byte_cnt_o   <= cnt_nx;
            if (emit)
                byte_o <= sr;
            if (byte_rdy && (state == RX) && !in_limit)
                err_long_o <= 1'b1;

            case (state)
                IDLE: begin
                    if (bit_valid_in) begin
                        state       <= RX;
                        len         <= length_in;
                        byte_cnt_o  <= '0;
                        err_short_o <= 1'b0;
                        err_long_o  <= 1'b0;
                        err_align_o <= 1'b0;
                        sr          <= {sr[6:0], bit_in};
                        bit_cnt     <= 3'd1;
                    end
                end
                RX: begin
                    if (bit_valid_in) begin
                        sr      <= {sr[6:0], bit_in};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            byte_rdy <= 1'b1;
                    end else begin
                        state       <= END;
                        done_o      <= 1'b1;
                        err_align_o <= (bit_cnt != 3'd0);
                        err_short_o <= (len != '0) && (cnt_nx < len);
                        bit_cnt     <= '0;
                    end
                end
                END:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    bit_deser_byte_packer #(
        .ADDR_W(ADDR_W)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_stb   (emit),
        .byte_in    (sr),
        .flush      (flush),
        .ram_wr_o   (ram_wr_o),
        .ram_addr_o (ram_addr_o),
        .ram_data_o (ram_data_o)
    );

endmodule

// File: tb/tb_bit_deser.sv
// Scoreboard bench for bit_deser: a frame model pushes expected bytes, writes
// and end-of-frame status; a negedge monitor pops and compares.
module tb_bit_deser;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              rst;
    logic              bit_in;
    logic              bit_valid_in;
    logic [LEN_W-1:0]  length_in;
    logic [7:0]        byte_o;
    logic              byte_valid_o;
    logic              ram_wr_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [31:0]       ram_data_o;
    logic              done_o;
    logic [LEN_W-1:0]  byte_cnt_o;
    logic              err_short_o;
    logic              err_long_o;
    logic              err_align_o;
    logic [1:0]        fsm_state_o;

    bit_deser #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_valid_in (bit_valid_in),
        .length_in    (length_in),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .ram_wr_o     (ram_wr_o),
        .ram_addr_o   (ram_addr_o),
        .ram_data_o   (ram_data_o),
        .done_o       (done_o),
        .byte_cnt_o   (byte_cnt_o),
        .err_short_o  (err_short_o),
        .err_long_o   (err_long_o),
        .err_align_o  (err_align_o),
        .fsm_state_o  (fsm_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]           exp_byte_q[$];
    logic [ADDR_W+31:0]   exp_wr_q[$];
    logic [LEN_W+2:0]     exp_done_q[$];
    logic [7:0]           tx[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (byte_valid_o) begin
                check("byte_expected", 64'(exp_byte_q.size() != 0), 64'd1);
                if (exp_byte_q.size() != 0)
                    check("byte_data", 64'(byte_o), 64'(exp_byte_q.pop_front()));
            end
            if (ram_wr_o) begin
                check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0)
                    check("wr_addr_data", 64'({ram_addr_o, ram_data_o}), 64'(exp_wr_q.pop_front()));
            end
            if (done_o) begin
                check("done_state", 64'(fsm_state_o), 64'd2);
                check("done_expected", 64'(exp_done_q.size() != 0), 64'd1);
                if (exp_done_q.size() != 0)
                    check("done_cnt_flags",
                          64'({byte_cnt_o, err_short_o, err_long_o, err_align_o}),
                          64'(exp_done_q.pop_front()));
            end
        end
    end

    // driver: model the frame, then shift its bits out MSB first
    task automatic send_frame(input int nbits, input int len, input int gap);
        int nb, acc;
        logic [ADDR_W-1:0] addr;
        logic [31:0] word;
        logic [7:0] cur;
        nb   = nbits / 8;
        acc  = (len == 0) ? nb : ((nb < len) ? nb : len);
        addr = '0;
        word = '0;
        for (int k = 0; k < acc; k++) begin
            exp_byte_q.push_back(tx[k]);
            word[8*(k%4) +: 8] = tx[k];
            if ((k % 4 == 3) || (k == acc - 1)) begin
                exp_wr_q.push_back({addr, word});
                addr = addr + ADDR_W'(4);
                word = '0;
            end
        end
        exp_done_q.push_back({LEN_W'(acc),
                              (len != 0) && (acc < len),
                              (len != 0) && (nb > len),
                              (nbits % 8) != 0});
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            cur          = tx[i/8];
            bit_in       = cur[7 - (i % 8)];
            bit_valid_in = 1'b1;
            length_in    = LEN_W'(len);
        end
        @(posedge clk); #1;
        bit_valid_in = 1'b0;
        bit_in       = 1'b0;
        length_in    = '0;
        repeat (gap - 1) @(posedge clk);
    endtask

    task automatic set_tx(input logic [63:0] b);
        for (int k = 0; k < 8; k++) tx[k] = b[63 - 8*k -: 8];
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_byte_q.size() + exp_wr_q.size() + exp_done_q.size()) != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_bytes", 64'(exp_byte_q.size()), 64'd0);
        check("drain_writes", 64'(exp_wr_q.size()), 64'd0);
        check("drain_done", 64'(exp_done_q.size()), 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        bit_in       = 1'b0;
        bit_valid_in = 1'b0;
        length_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              64'({byte_o, byte_valid_o, ram_wr_o, done_o, byte_cnt_o,
                   err_short_o, err_long_o, err_align_o, fsm_state_o}), 64'd0);
        check("reset_ram", 64'({ram_addr_o, ram_data_o}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        set_tx(64'hA53C0FF000000000); send_frame(32, 4, 2); wait_drain();
        set_tx(64'h0102030405060000); send_frame(48, 0, 2); wait_drain();
        set_tx(64'hAABBCCDDEE000000); send_frame(40, 3, 2); wait_drain();
        set_tx(64'h1122000000000000); send_frame(16, 4, 2); wait_drain();
        set_tx(64'h5AE0000000000000); send_frame(11, 0, 2); wait_drain();
        set_tx(64'h8000000000000000); send_frame(1, 0, 2);  wait_drain();

        // abort after 13 bits: the first byte is already out, nothing else is
        set_tx(64'h77FF000000000000);
        exp_byte_q.push_back(8'h77);
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            bit_in       = tx[i/8][7 - (i % 8)];
            bit_valid_in = 1'b1;
        end
        @(posedge clk); #1;
        rst          = 1'b1;
        bit_valid_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        set_tx(64'h8100000000000000); send_frame(8, 0, 2); wait_drain();

        // back-to-back frames, minimum gap
        set_tx(64'h123456789A000000); send_frame(40, 0, 2);
        set_tx(64'hC33C000000000000); send_frame(16, 2, 2);
        wait_drain();

        for (int r = 0; r < 6; r++) begin
            set_tx({$urandom, $urandom});
            send_frame($urandom_range(1, 64), $urandom_range(0, 9), $urandom_range(2, 4));
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_deser.md
Name: bit_deser

Overview:
- Receive-side counterpart of the oserdes bit serializer: recovers bytes from a serial bit stream framed by a valid strobe.
- Packs the recovered bytes into 32-bit words and writes them into a PL data RAM port, using byte addressing with a +4 step per word.
- Reports per-frame byte count and error status, so serializer loopback and external links can be checked from the PS side.
- Sits in the serializer clock domain (clk_300m in the top level), next to oserdes.

Parameters:
- ADDR_W, 10, width of ram_addr_o (byte address; word step 4).
- LEN_W, 8, width of length_in and byte_cnt_o.

Ports:
- clk  in  1  bit-rate clock; one bit is sampled per cycle while bit_valid_in=1.
- rst  in  1  synchronous, active-high reset.
- bit_in  in  1  serial data, MSB of each byte first.
- bit_valid_in  in  1  frame strobe; contiguous high for the whole frame.
- length_in  in  LEN_W  expected byte count; 0 = unlimited. Captured on the first valid bit of a frame.
- byte_o  out  8  last recovered byte.
- byte_valid_o  out  1  one-cycle pulse per recovered byte.
- ram_wr_o  out  1  one-cycle word write strobe.
- ram_addr_o  out  ADDR_W  byte address of ram_data_o.
- ram_data_o  out  32  packed word; first byte of the word in [7:0].
- done_o  out  1  one-cycle end-of-frame pulse.
- byte_cnt_o  out  LEN_W  bytes accepted in the current/last frame; saturates at all-ones.
- err_short_o, err_long_o, err_align_o  out  1 each  per-frame status flags.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0.
- Registered outputs: everything updates on the clk edge.
- FSM states:
  - IDLE: bit_valid_in=1 -> RX. In that cycle: capture length_in, clear byte_cnt and the error flags, set word address to 0, shift in the first bit.
  - RX: shift bit_in while valid=1. When valid=0 -> END.
  - END: lasts exactly 1 cycle, then -> IDLE.
- Byte assembly:
  - 3-bit bit counter; MSB-first shift.
  - On the 8th bit, byte_o/byte_valid_o assert on the following cycle.
  - Byte k of the frame is placed in lane k mod 4 of ram_data_o.
- Word write:
  - When lane 3 fills, ram_wr_o pulses in the same cycle as that byte's byte_valid_o, with the completed word on ram_data_o.
  - ram_addr_o is then advanced by 4 after the write. It wraps modulo 2^ADDR_W.
- Length limit:
  - When length_in≠0, bytes beyond length_in are not emitted and not written, and err_long_o is set.
  - byte_cnt_o counts accepted bytes only.
- END cycle actions:
  - Pending partial word: if 1–3 lanes are filled, they are written with the unused upper lanes zero-filled (ram_wr_o=1).
  - Leftover bits: if the bit counter ≠0, the partial byte is discarded and err_align_o is set.
  - Short frame: if length_in≠0 and byte_cnt < length, err_short_o is set.
  - done_o pulses with the final flag values.
  - Flags and byte_cnt_o hold until the next frame start.
- Simultaneous end events: if the 8th bit completes in the last RX cycle, the byte pulse lands in the END cycle together with any flush write and done_o. The flush then includes that byte.
- Inter-frame gap: minimum 2 valid-low cycles. A valid=1 sample in END is dropped. The next frame starts only from IDLE; if valid is still high in IDLE, it starts a new frame with a fresh capture.
- Empty frame: a 1-cycle frame of 1 bit gives no byte, no write, done_o=1, err_align_o=1.
- rst mid-frame: immediate return to IDLE, with no done_o and no flush.

Decomposition:
- Shared package (shared with oserdes): FSM state enum {IDLE, RX, END}, BYTE_W=8, WORD_BYTES=4, ADDR_STEP=4.
- Sub-module byte_packer: lane fill, zero-padded flush, address increment/wrap. The FSM and shift register stay in bit_deser.

Test Plan:
- Frame of 32 bits (0xA5,0x3C,0x0F,0xF0), length_in=4:
  - 4 byte_valid_o pulses.
  - One write, addr 0x000, data 0xF00F3CA5.
  - done_o=1, byte_cnt_o=4, all error flags 0.
- 6 bytes 0x01..0x06, length_in=0:
  - Writes (0x000, 0x04030201) and (0x004, 0x00000605); the second is the flush, in the END cycle.
  - done_o=1, byte_cnt_o=6.
- 5 bytes, length_in=3:
  - Only 3 byte pulses.
  - Flush write (0x000, 0x00CCBBAA) for bytes AA,BB,CC.
  - err_long_o=1, byte_cnt_o=3.
- 2 bytes, length_in=4 → err_short_o=1, byte_cnt_o=2.
- 11 bits → 1 byte accepted, err_align_o=1, flush write with lane0 only.
- Reset mid-frame after 13 bits, then a valid 8-bit frame of 0x81:
  - No done_o for the aborted frame.
  - New frame writes (0x000, 0x00000081).
- Back-to-back frames with a 2-cycle gap: both frames are received intact, and addresses restart at 0 for each.
